alu_sched: RTL and testbench
============================

Name: alu_sched

Overview:
- Sequencer for the stateless 16-bit ALU/AGU datapath.
- Accepts one decoded micro-op per handshake and drives the datapath controls: ALU function, carry mask, operand bypass, AGU displacement and zero-index.
- Runs the LSU request/acknowledge handshake for load-operate and store ops.
- Issues register-file and status-flag write enables on the execute cycle.

Parameters:
- WAIT_MAX, 15: maximum LSU wait cycles before the op is aborted with a bus error (legal range 1..255).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- dec_valid  in  1  decoded micro-op present
- dec_ready  out  1  scheduler accepts micro-op this cycle
- dec_op  in  4  ALU function code for the op
- dec_mode  in  2  00 reg-reg, 01 immediate, 10 load-operate, 11 store
- dec_use_carry  in  1  carry-in enabled (ADC/SBC/ROL/ROR)
- dec_flags_we  in  1  op updates status flags
- dec_zero_index  in  1  AGU base forced to zero (absolute addressing)
- dec_imm  in  16  immediate operand
- dec_disp  in  16  address displacement/absolute address
- alu_f  out  4  ALU function select
- carry_mask  out  1  ALU carry-in enable
- sched_t16  out  16  bypass operand to ALU B side
- sched_agu_t16  out  16  AGU displacement
- sched_bypass_b  out  1  select sched_t16 over rf_b
- sched_zero_index  out  1  AGU zero-base select
- lsu_req  out  1  memory request
- lsu_we  out  1  1 = store, 0 = load
- lsu_ack  in  1  LSU completion; load data valid same cycle
- lsu_rdata  in  16  load data
- rf_we  out  1  register-file write of ALU result
- sf_we  out  1  status-flag register write
- busy  out  1  op in flight (any state except IDLE)
- bus_err  out  1  one-cycle pulse, LSU timeout

Behaviour:
- Reset (async): state IDLE. Latched op fields and wait counter cleared. All outputs 0 except dec_ready=1.
- States: IDLE, EXEC, MEM, LEXEC, ERR. Op fields are latched on the accept cycle (dec_valid & dec_ready).
- dec_ready=1 in IDLE and EXEC only. Accepting in EXEC gives back-to-back reg/imm ops with throughput 1 op/cycle and latency 1 (controls appear the cycle after accept).
- IDLE/accept transitions: mode 00/01 -> EXEC; mode 10/11 -> MEM; no accept -> stay in IDLE.
- EXEC:
  - alu_f=op, carry_mask=use_carry, rf_we=1, sf_we=flags_we.
  - Mode 01: sched_bypass_b=1, sched_t16=imm. Mode 00: bypass 0.
  - Next state: new accept -> per its mode; else IDLE.
- MEM:
  - lsu_req=1, lsu_we=(mode==11), sched_agu_t16=disp, sched_zero_index=zero_index.
  - These are held stable until ack or timeout. rf_we=sf_we=0.
  - lsu_ack sampled each rising edge; ack in the first MEM cycle is legal (1-cycle memory).
  - On ack: load -> capture lsu_rdata into t16 register, go to LEXEC; store -> IDLE.
- LEXEC: alu_f=op, carry_mask=use_carry, sched_bypass_b=1, sched_t16=captured data, rf_we=1, sf_we=flags_we. Next state IDLE.
- Wait counter: 8-bit, cleared on MEM entry, increments each MEM cycle without ack.
- Timeout: count==WAIT_MAX with no ack -> ERR. Ack arriving on the same cycle as the timeout wins (completion).
- ERR: bus_err=1 for exactly one cycle, no rf_we/sf_we, op discarded, next state IDLE.
- Outside the active states: alu_f, carry_mask, sched_t16, sched_agu_t16, sched_bypass_b, sched_zero_index, lsu_req, lsu_we all 0.
- All outputs are registered-state decodes; no combinational path from dec_* to datapath controls.
- Reset mid-MEM: lsu_req drops asynchronously. The LSU must discard the transaction, and a late ack is ignored in IDLE.
- lsu_ack outside MEM: ignored.

Optional Feature:
- Macro ALU_SCHED_STALL_CNT_EN.
- Defined: adds output port stall_cnt (16 bits). Increments by 1 every MEM cycle without lsu_ack and saturates at 16'hFFFF. Cleared only by rst.
- Undefined: port and counter are absent; the rest of the behaviour is identical.

Test Plan:
- Reset with dec_valid=1 held: all outputs 0, dec_ready=1. The first edge after rst release accepts the op.
- Three back-to-back imm ops (op=0000, imm=16'h0001/0002/0003): alu_f=0000 and bypass=1 with t16=1,2,3 on consecutive cycles; rf_we=1 for 3 cycles; dec_ready stays 1.
- Load-operate op=0101, disp=16'h1234, zero_index=1, ack after 3 cycles with rdata=16'h00F0:
  - lsu_req=1, lsu_we=0, agu_t16=16'h1234 for 3 cycles.
  - Then LEXEC with t16=16'h00F0, alu_f=0101, rf_we=1, then IDLE.
- Store, ack in first MEM cycle: lsu_req=1, lsu_we=1 for 1 cycle, rf_we never asserted, back to IDLE next cycle.
- WAIT_MAX=4, load with no ack:
  - lsu_req high for 5 cycles, then bus_err pulses 1 cycle with no rf_we.
  - With the feature enabled, stall_cnt=5 afterwards.
- rst asserted during MEM: lsu_req=0 immediately; a subsequent lsu_ack causes no rf_we.

Source files
------------

// File: rtl/alu_sched.sv
// alu_sched: micro-op sequencer for the 16-bit ALU/AGU datapath and LSU handshake.
// Optional macro ALU_SCHED_STALL_CNT_EN adds a saturating LSU stall counter output.
module alu_sched #(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [3:0]  dec_op,
    input  logic [1:0]  dec_mode,
    input  logic        dec_use_carry,
    input  logic        dec_flags_we,
    input  logic        dec_zero_index,
    input  logic [15:0] dec_imm,
    input  logic [15:0] dec_disp,
    output logic [3:0]  alu_f,
    output logic        carry_mask,
    output logic [15:0] sched_t16,
    output logic [15:0] sched_agu_t16,
    output logic        sched_bypass_b,
    output logic        sched_zero_index,
    output logic        lsu_req,
    output logic        lsu_we,
    input  logic        lsu_ack,
    input  logic [15:0] lsu_rdata,
    output logic        rf_we,
    output logic        sf_we,
    output logic        busy,
    output logic        bus_err
`ifdef ALU_SCHED_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, EXEC, MEM, LEXEC, ERR} state_t;

    localparam logic [7:0] WMAX = WAIT_MAX[7:0];

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  mode_q, mode_d;
    logic        uc_q, uc_d;
    logic        fwe_q, fwe_d;
    logic        zi_q, zi_d;
    logic [15:0] t16_q, t16_d;
    logic [15:0] disp_q, disp_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        accept;

    assign accept = dec_valid & dec_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            mode_q  <= '0;
            uc_q    <= 1'b0;
            fwe_q   <= 1'b0;
            zi_q    <= 1'b0;
            t16_q   <= '0;
            disp_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            mode_q  <= mode_d;
            uc_q    <= uc_d;
            fwe_q   <= fwe_d;
            zi_q    <= zi_d;
            t16_q   <= t16_d;
            disp_q  <= disp_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        mode_d  = mode_q;
        uc_d    = uc_q;
        fwe_d   = fwe_q;
        zi_d    = zi_q;
        t16_d   = t16_q;
        disp_d  = disp_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            IDLE:  state_d = IDLE;
            EXEC:  state_d = IDLE;
            MEM: begin
                // A late ack on the timeout cycle still completes the op.
                if (lsu_ack) begin
                    if (mode_q[0]) begin
                        state_d = IDLE;
                    end else begin
                        t16_d   = lsu_rdata;
                        state_d = LEXEC;
                    end
                end else if (wcnt_q == WMAX) begin
                    state_d = ERR;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            LEXEC: state_d = IDLE;
            ERR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            op_d    = dec_op;
            mode_d  = dec_mode;
            uc_d    = dec_use_carry;
            fwe_d   = dec_flags_we;
            zi_d    = dec_zero_index;
            t16_d   = dec_imm;
            disp_d  = dec_disp;
            wcnt_d  = '0;
            state_d = dec_mode[1] ? MEM : EXEC;
        end
    end

    // Every control is a decode of registered state only.
    always_comb begin
        dec_ready        = 1'b0;
        alu_f            = '0;
        carry_mask       = 1'b0;
        sched_t16        = '0;
        sched_agu_t16    = '0;
        sched_bypass_b   = 1'b0;
        sched_zero_index = 1'b0;
        lsu_req          = 1'b0;
        lsu_we           = 1'b0;
        rf_we            = 1'b0;
        sf_we            = 1'b0;
        bus_err          = 1'b0;
        busy             = (state_q != IDLE);
        unique case (state_q)
            IDLE: dec_ready = 1'b1;
            EXEC: begin
                dec_ready  = 1'b1;
                alu_f      = op_q;
                carry_mask = uc_q;
                rf_we      = 1'b1;
                sf_we      = fwe_q;
                if (mode_q == 2'b01) begin
                    sched_bypass_b = 1'b1;
                    sched_t16      = t16_q;
                end
            end
            MEM: begin
                lsu_req          = 1'b1;
                lsu_we           = mode_q[0];
                sched_agu_t16    = disp_q;
                sched_zero_index = zi_q;
            end
            LEXEC: begin
                alu_f          = op_q;
                carry_mask     = uc_q;
                sched_bypass_b = 1'b1;
                sched_t16      = t16_q;
                rf_we          = 1'b1;
                sf_we          = fwe_q;
            end
            ERR: bus_err = 1'b1;
            default: ;
        endcase
    end

`ifdef ALU_SCHED_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (state_q == MEM && !lsu_ack && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: driver pushes expected events, monitor pops on DUT activity.
module tb_alu_sched;
    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid, dec_ready;
    logic [3:0]  dec_op;
    logic [1:0]  dec_mode;
    logic        dec_use_carry, dec_flags_we, dec_zero_index;
    logic [15:0] dec_imm, dec_disp;
    logic [3:0]  alu_f;
    logic        carry_mask;
    logic [15:0] sched_t16, sched_agu_t16;
    logic        sched_bypass_b, sched_zero_index;
    logic        lsu_req, lsu_we, lsu_ack;
    logic [15:0] lsu_rdata;
    logic        rf_we, sf_we, busy, bus_err;
    logic        ack_auto, ack_man;
`ifdef ALU_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    assign lsu_ack = ack_auto | ack_man;

    always #5 clk = ~clk;

    alu_sched #(.WAIT_MAX(W)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_op(dec_op), .dec_mode(dec_mode),
        .dec_use_carry(dec_use_carry), .dec_flags_we(dec_flags_we),
        .dec_zero_index(dec_zero_index), .dec_imm(dec_imm), .dec_disp(dec_disp),
        .alu_f(alu_f), .carry_mask(carry_mask),
        .sched_t16(sched_t16), .sched_agu_t16(sched_agu_t16),
        .sched_bypass_b(sched_bypass_b), .sched_zero_index(sched_zero_index),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_ack(lsu_ack), .lsu_rdata(lsu_rdata),
        .rf_we(rf_we), .sf_we(sf_we), .busy(busy), .bus_err(bus_err)
`ifdef ALU_SCHED_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    // kind: 0 = register write, 1 = memory request, 2 = bus error
    typedef struct {
        int          kind;
        logic [3:0]  f;
        logic        cm;
        logic        byp;
        logic [15:0] t16;
        logic        sf;
        logic        we;
        logic [15:0] disp;
        logic        zi;
        int          len;
    } exp_t;

    exp_t        expq[$];
    int          ackd_q[$];
    logic [15:0] ackdat_q[$];
    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 1'b0;
    longint      stall_model = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_exp(input int kind, input string name, output bit ok, output exp_t e);
        checks++;
        ok = 1'b0;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL %s: got unexpected event, expected none", name);
        end else begin
            e = expq.pop_front();
            if (e.kind != kind) begin
                errors++;
                $display("FAIL %s: got event kind %0d expected kind %0d", name, kind, e.kind);
            end else begin
                ok = 1'b1;
            end
        end
    endtask

    // Reference: a reg/imm op writes once; a memory op requests for min(d, W+1) cycles,
    // then a load writes its data through the bypass, or a timeout raises bus_err.
    task automatic issue(input logic [3:0] op, input logic [1:0] mode, input logic uc,
                         input logic fwe, input logic zi, input logic [15:0] imm,
                         input logic [15:0] disp, input int d, input logic [15:0] rdata,
                         output int waits);
        exp_t e;
        bit   done;
        dec_valid = 1'b1; dec_op = op; dec_mode = mode; dec_use_carry = uc;
        dec_flags_we = fwe; dec_zero_index = zi; dec_imm = imm; dec_disp = disp;
        if (mode[1]) begin
            ackd_q.push_back(d);
            ackdat_q.push_back(rdata);
        end
        waits = 0;
        while (1) begin
            @(negedge clk);
            if (dec_ready) break;
            waits++;
            if (waits > 50) begin
                errors++; checks++;
                $display("FAIL accept_timeout: got no dec_ready in %0d cycles, expected acceptance", waits);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $fatal(1, "accept timeout");
            end
        end
        @(posedge clk); #1;
        e = '{kind: 0, f: op, cm: uc, byp: 1'b0, t16: 16'h0, sf: fwe,
              we: 1'b0, disp: 16'h0, zi: 1'b0, len: 0};
        if (!mode[1]) begin
            e.byp = mode[0];
            e.t16 = mode[0] ? imm : 16'h0;
            expq.push_back(e);
        end else begin
            done = (d <= W + 1);
            expq.push_back('{kind: 1, f: 4'h0, cm: 1'b0, byp: 1'b0, t16: 16'h0, sf: 1'b0,
                             we: mode[0], disp: disp, zi: zi, len: done ? d : W + 1});
            stall_model += done ? d - 1 : W + 1;
            if (done && !mode[0]) begin
                e.byp = 1'b1;
                e.t16 = rdata;
                expq.push_back(e);
            end else if (!done) begin
                expq.push_back('{kind: 2, f: 4'h0, cm: 1'b0, byp: 1'b0, t16: 16'h0, sf: 1'b0,
                                 we: 1'b0, disp: 16'h0, zi: 1'b0, len: 0});
            end
        end
    endtask

    task automatic idle(input int n);
        dec_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // LSU model: acks in the d-th request cycle of each transaction.
    initial begin
        int          cyc = 0;
        int          cur_d = 0;
        logic [15:0] cur_dat = 16'h0;
        ack_auto  = 1'b0;
        lsu_rdata = 16'h0;
        forever begin
            @(negedge clk);
            if (lsu_req && !rst) begin
                cyc++;
                if (cyc == 1) begin
                    cur_d   = (ackd_q.size() != 0) ? ackd_q.pop_front() : 1000;
                    cur_dat = (ackdat_q.size() != 0) ? ackdat_q.pop_front() : 16'h0;
                end
                ack_auto  = (cyc == cur_d);
                lsu_rdata = ack_auto ? cur_dat : 16'hDEAD;
            end else begin
                cyc      = 0;
                ack_auto = 1'b0;
            end
        end
    end

    initial begin
        bit          prev = 1'b0;
        bit          stable = 1'b1;
        bit          clean = 1'b1;
        bit          ok;
        int          len = 0;
        logic        we0 = 1'b0;
        logic        zi0 = 1'b0;
        logic [15:0] disp0 = 16'h0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev = 1'b0;
                continue;
            end
            if (lsu_req) begin
                if (!prev) begin
                    len = 1; we0 = lsu_we; disp0 = sched_agu_t16; zi0 = sched_zero_index;
                    stable = 1'b1; clean = 1'b1;
                end else begin
                    len++;
                    if ({lsu_we, sched_agu_t16, sched_zero_index} !== {we0, disp0, zi0}) stable = 1'b0;
                end
                if (rf_we || sf_we || !busy || dec_ready || bus_err) clean = 1'b0;
            end else if (prev) begin
                pop_exp(1, "mem_event", ok, e);
                if (ok) begin
                    chk("mem_we", we0, e.we);
                    chk("mem_disp", disp0, e.disp);
                    chk("mem_zi", zi0, e.zi);
                    chk("mem_len", len, e.len);
                    chk("mem_stable", stable, 1);
                    chk("mem_clean", clean, 1);
                end
            end
            if (!lsu_req && (rf_we || sf_we)) begin
                pop_exp(0, "exec_event", ok, e);
                if (ok) begin
                    chk("exec_rf_we", rf_we, 1);
                    chk("exec_alu_f", alu_f, e.f);
                    chk("exec_carry", carry_mask, e.cm);
                    chk("exec_bypass", sched_bypass_b, e.byp);
                    chk("exec_t16", sched_t16, e.t16);
                    chk("exec_sf_we", sf_we, e.sf);
                    chk("exec_busy", busy, 1);
                end
            end
            if (bus_err) begin
                pop_exp(2, "err_event", ok, e);
                if (ok) chk("err_no_write", {rf_we, sf_we}, 0);
            end
            if (!lsu_req && !rf_we && !sf_we)
                chk("idle_ctl", {alu_f, carry_mask, sched_t16, sched_agu_t16,
                                 sched_bypass_b, sched_zero_index, lsu_we}, 0);
            prev = lsu_req;
        end
    end

    initial begin
        int w;
        int mode;
        rst = 1'b1; ack_man = 1'b0;
        dec_valid = 1'b1; dec_op = 4'h0; dec_mode = 2'b01; dec_use_carry = 1'b0;
        dec_flags_we = 1'b0; dec_zero_index = 1'b0; dec_imm = 16'h0001; dec_disp = 16'h0;

        repeat (3) @(negedge clk);
        chk("reset_ready", dec_ready, 1);
        chk("reset_outs", {alu_f, carry_mask, sched_t16, sched_agu_t16, sched_bypass_b,
                           sched_zero_index, lsu_req, lsu_we, rf_we, sf_we, busy, bus_err}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        issue(4'h0, 2'b01, 0, 0, 0, 16'h0001, 16'h0, 0, 16'h0, w);
        chk("first_accept_wait", w, 0);
        issue(4'h0, 2'b01, 0, 0, 0, 16'h0002, 16'h0, 0, 16'h0, w);
        chk("b2b_wait_2", w, 0);
        issue(4'h0, 2'b01, 0, 0, 0, 16'h0003, 16'h0, 0, 16'h0, w);
        chk("b2b_wait_3", w, 0);
        issue(4'h7, 2'b00, 1, 1, 0, 16'hBEEF, 16'h0, 0, 16'h0, w);
        chk("b2b_wait_reg", w, 0);

        issue(4'b0101, 2'b10, 0, 1, 1, 16'h0, 16'h1234, 3, 16'h00F0, w);
        issue(4'h3, 2'b11, 0, 0, 0, 16'h0, 16'hA5A5, 1, 16'h0, w);
        issue(4'h9, 2'b10, 1, 1, 0, 16'h0, 16'h0F0F, W + 2, 16'h1111, w);
        issue(4'hC, 2'b10, 0, 0, 1, 16'h0, 16'h4321, W + 1, 16'h2222, w);
        issue(4'h2, 2'b11, 0, 1, 1, 16'h0, 16'h5555, 100, 16'h0, w);
        idle(2);

        for (int i = 0; i < 60; i++) begin
            mode = $urandom_range(0, 3);
            issue(4'($urandom), 2'(mode), 1'($urandom), 1'($urandom), 1'($urandom),
                  16'($urandom), 16'($urandom), $urandom_range(1, W + 3), 16'($urandom), w);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(12);
        chk("scoreboard_drain", expq.size(), 0);
`ifdef ALU_SCHED_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, stall_model[15:0]);
`endif

        mon_en = 1'b0;
        issue(4'h6, 2'b10, 0, 1, 0, 16'h0, 16'h7777, 1000, 16'h0, w);
        idle(0);
        @(negedge clk);
        chk("rst_mem_req_before", lsu_req, 1);
        #2 rst = 1'b1;
        #1 chk("rst_mem_req_drop", lsu_req, 0);
        chk("rst_mem_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ack_man = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_ack_no_rf_we", {rf_we, sf_we, lsu_req, bus_err}, 0);
            ack_man = 1'b0;
        end
        expq.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, expected $finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end
endmodule
